// File: rtl/alarm_annunciator_if.sv
// Bundles the alert/ack inputs and the annunciator outputs between the alarm FSM side and the pin side.
interface alarm_annunciator_if;
    logic       alert_in;
    logic       ack_pulse;
    logic       buzz_out;
    logic       led_out;
    logic       busy;
    logic [7:0] burst_cnt;

    modport master (output alert_in, ack_pulse,
                    input  buzz_out, led_out, busy, burst_cnt);
    modport slave  (input  alert_in, ack_pulse,
                    output buzz_out, led_out, busy, burst_cnt);
endinterface

// File: rtl/alarm_annunciator.sv
// Turns the alarm FSM's alert level into a timed beep/pause buzzer pattern and a steady LED.
// Optional ANNUNCIATOR_ESCALATE_EN: after four completed bursts the pause is dropped (continuous beeping).
module alarm_annunciator #(
    parameter int ON_CYCLES    = 8,
    parameter int OFF_CYCLES   = 8,
    parameter int BEEP_COUNT   = 4,
    parameter int PAUSE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    alarm_annunciator_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ON    = 3'd1,
        S_OFF   = 3'd2,
        S_PAUSE = 3'd3,
        S_SIL   = 3'd4
    } state_t;

    localparam logic [7:0] ON_LAST    = 8'(ON_CYCLES - 1);
    localparam logic [7:0] OFF_LAST   = 8'(OFF_CYCLES - 1);
    localparam logic [7:0] BEEP_LAST  = 8'(BEEP_COUNT - 1);
    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_CYCLES - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t     r_state, w_state_nxt;
    logic [7:0] r_timer, w_timer_nxt;
    logic [7:0] r_beep,  w_beep_nxt;
    logic [7:0] r_bursts, w_bursts_nxt;
    logic       w_skip_pause;
    logic       w_buzz, w_led, w_busy;
    logic       r_buzz, r_led, r_busy;
    logic [7:0] r_burst_cnt;

`ifdef ANNUNCIATOR_ESCALATE_EN
    // Tested against the count before this burst is added, so bursts 1..4 still pause.
    assign w_skip_pause = (r_bursts >= 8'd4);
`else
    assign w_skip_pause = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= 8'd0;
            r_beep      <= 8'd0;
            r_bursts    <= 8'd0;
            r_buzz      <= 1'b0;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
            r_burst_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_beep      <= w_beep_nxt;
            r_bursts    <= w_bursts_nxt;
            r_buzz      <= w_buzz;
            r_led       <= w_led;
            r_busy      <= w_busy;
            r_burst_cnt <= r_bursts;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_beep_nxt   = r_beep;
        w_bursts_nxt = r_bursts;
        case (r_state)
            S_IDLE: begin
                // burst count is cleared only on leaving IDLE so it stays readable afterwards
                if (bus.alert_in) begin
                    w_state_nxt  = S_ON;
                    w_timer_nxt  = 8'd0;
                    w_beep_nxt   = 8'd0;
                    w_bursts_nxt = 8'd0;
                end
            end
            S_SIL: begin
                if (!bus.alert_in) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = 8'd0;
                end
            end
            default: begin
                if (!bus.alert_in) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = 8'd0;
                end else if (bus.ack_pulse) begin
                    w_state_nxt = S_SIL;
                end else begin
                    case (r_state)
                        S_ON: begin
                            if (r_timer == ON_LAST) begin
                                w_state_nxt = S_OFF;
                                w_timer_nxt = 8'd0;
                            end else begin
                                w_timer_nxt = r_timer + 8'd1;
                            end
                        end
                        S_OFF: begin
                            if (r_timer == OFF_LAST) begin
                                w_timer_nxt = 8'd0;
                                if (r_beep == BEEP_LAST) begin
                                    w_bursts_nxt = sat_inc8(r_bursts);
                                    w_beep_nxt   = 8'd0;
                                    w_state_nxt  = w_skip_pause ? S_ON : S_PAUSE;
                                end else begin
                                    w_beep_nxt  = r_beep + 8'd1;
                                    w_state_nxt = S_ON;
                                end
                            end else begin
                                w_timer_nxt = r_timer + 8'd1;
                            end
                        end
                        S_PAUSE: begin
                            if (r_timer == PAUSE_LAST) begin
                                w_state_nxt = S_ON;
                                w_timer_nxt = 8'd0;
                                w_beep_nxt  = 8'd0;
                            end else begin
                                w_timer_nxt = r_timer + 8'd1;
                            end
                        end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        w_buzz = 1'b0;
        w_led  = 1'b0;
        w_busy = 1'b0;
        if (r_state != S_IDLE) begin
            w_led  = 1'b1;
            w_busy = 1'b1;
        end
        if (r_state == S_ON) begin
            w_buzz = 1'b1;
        end
    end

    assign bus.buzz_out  = r_buzz;
    assign bus.led_out   = r_led;
    assign bus.busy      = r_busy;
    assign bus.burst_cnt = r_burst_cnt;

endmodule
